// File: rtl/arb_requester.sv
// arb_requester: client-side request/grant agent for the four-way bus arbiter.
// Define ARB_TIMEOUT_EN to abort a request that waits more than TIMEOUT cycles for gnt.
module arb_requester #(
  parameter int BURST_W    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               gnt,
  output logic               req,
  output logic               busy,
  output logic               own,
  output logic [BURST_W-1:0] beat,
  output logic               done,
  output logic               abort
);
  typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} state_t;
  // GAP always lasts at least one cycle, even when GAP_CYCLES is 0
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  state_t             r_state, w_state;
  logic               r_req, w_req, r_busy, w_busy, r_own, w_own, r_done, w_done;
  logic [BURST_W-1:0] r_beat, w_beat, r_len, w_len;
  logic [1:0]         r_gap, w_gap;
  logic               w_abort;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_wait, w_wait;
  logic          r_abort;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wait  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_wait  <= w_wait;
      r_abort <= w_abort;
    end
  assign abort = r_abort;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_own   <= 1'b0;
      r_done  <= 1'b0;
      r_beat  <= '0;
      r_len   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_busy  <= w_busy;
      r_own   <= w_own;
      r_done  <= w_done;
      r_beat  <= w_beat;
      r_len   <= w_len;
      r_gap   <= w_gap;
    end
  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_busy  = r_busy;
    w_own   = r_own;
    w_done  = 1'b0;
    w_abort = 1'b0;
    w_beat  = r_beat;
    w_len   = r_len;
    w_gap   = r_gap;
`ifdef ARB_TIMEOUT_EN
    w_wait  = r_wait;
`endif
    case (r_state)
      IDLE:
        if (start) begin
          w_state = REQ;
          w_req   = 1'b1;
          w_busy  = 1'b1;
          w_len   = burst_len;
`ifdef ARB_TIMEOUT_EN
          w_wait  = '0;
`endif
        end
      REQ:
        if (gnt) begin
          w_state = OWN;
          w_own   = 1'b1;
          w_beat  = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_wait == TW'(TIMEOUT - 1)) begin
          w_state = GAP;
          w_req   = 1'b0;
          w_abort = 1'b1;
          w_gap   = '0;
        end else
          w_wait = r_wait + 1'b1;
`endif
      OWN:
        // a lost grant ends the burst at once and suppresses done
        if (!gnt || r_beat == r_len) begin
          w_state = GAP;
          w_req   = 1'b0;
          w_own   = 1'b0;
          w_beat  = '0;
          w_done  = gnt;
          w_gap   = '0;
        end else
          w_beat = r_beat + 1'b1;
      GAP:
        if (r_gap == 2'(GAP_LAST)) begin
          w_state = IDLE;
          w_busy  = 1'b0;
        end else
          w_gap = r_gap + 1'b1;
      default: w_state = IDLE;
    endcase
  end
  assign req  = r_req;
  assign busy = r_busy;
  assign own  = r_own;
  assign beat = r_beat;
  assign done = r_done;
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed vector table plus hand-written multi-cycle sequences.
module tb_arb_requester;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, gnt = 1'b0;
  logic [3:0] burst_len = '0;
  logic       req, busy, own, done, abort;
  logic [3:0] beat;
  int errors = 0, checks = 0;
  typedef struct {
    logic       rst, start;
    logic [3:0] len;
    logic       gnt, req, busy, own;
    logic [3:0] beat;
    logic       done;
  } vec_t;
  vec_t vec[25];
  arb_requester #(.BURST_W(4), .GAP_CYCLES(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .gnt(gnt),
    .req(req), .busy(busy), .own(own), .beat(beat), .done(done), .abort(abort)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic s, logic [3:0] l, logic g,
                              logic eq, logic eb, logic eo, logic [3:0] ebt, logic ed);
    mk = '{r, s, l, g, eq, eb, eo, ebt, ed};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [8:0] got, logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {req,busy,own,beat,done,abort}=%b required %b", name, got, exp);
    end
  endtask
  function automatic logic [8:0] outs();
    outs = {req, busy, own, beat, done, abort};
  endfunction
  initial begin
    vec[0]  = mk(1,0,0,0, 0,0,0,0,0);
    vec[1]  = mk(0,0,0,0, 0,0,0,0,0);
    vec[2]  = mk(0,1,3,1, 1,1,0,0,0);
    vec[3]  = mk(0,0,0,1, 1,1,1,0,0);
    vec[4]  = mk(0,0,0,1, 1,1,1,1,0);
    vec[5]  = mk(0,0,0,1, 1,1,1,2,0);
    vec[6]  = mk(0,0,0,1, 1,1,1,3,0);
    vec[7]  = mk(0,0,0,1, 0,1,0,0,1);
    vec[8]  = mk(0,0,0,1, 0,0,0,0,0);
    vec[9]  = mk(0,1,0,0, 1,1,0,0,0);
    vec[10] = mk(0,0,0,0, 1,1,0,0,0);
    vec[11] = mk(0,1,9,0, 1,1,0,0,0);
    vec[12] = mk(0,0,0,0, 1,1,0,0,0);
    vec[13] = mk(0,0,0,0, 1,1,0,0,0);
    vec[14] = mk(0,0,0,1, 1,1,1,0,0);
    vec[15] = mk(0,1,0,1, 0,1,0,0,1);
    vec[16] = mk(0,1,0,1, 0,0,0,0,0);
    vec[17] = mk(0,0,0,1, 0,0,0,0,0);
    vec[18] = mk(0,1,7,1, 1,1,0,0,0);
    vec[19] = mk(0,0,0,1, 1,1,1,0,0);
    vec[20] = mk(0,0,0,1, 1,1,1,1,0);
    vec[21] = mk(0,0,0,1, 1,1,1,2,0);
    vec[22] = mk(0,0,0,1, 1,1,1,3,0);
    vec[23] = mk(0,0,0,0, 0,1,0,0,0);
    vec[24] = mk(0,0,0,0, 0,0,0,0,0);
    #2;
    chk("async_reset_initial", outs(), 9'b0);
    for (int i = 0; i < 25; i++) begin
      rst = vec[i].rst; start = vec[i].start; burst_len = vec[i].len; gnt = vec[i].gnt;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {vec[i].req, vec[i].busy, vec[i].own, vec[i].beat, vec[i].done, 1'b0});
    end
    start = 1'b1; burst_len = 4'd15; gnt = 1'b1;
    step();
    start = 1'b0;
    chk("max_req", outs(), {3'b110, 4'd0, 2'b00});
    for (int b = 0; b < 16; b++) begin
      step();
      chk($sformatf("max_beat%0d", b), outs(), {3'b111, 4'(b), 2'b00});
    end
    step();
    chk("max_done", outs(), {3'b010, 4'd0, 2'b10});
    step();
    chk("max_idle", outs(), 9'b0);
    start = 1'b1; burst_len = 4'd5; gnt = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("rst_pre_beat2", outs(), {3'b111, 4'd2, 2'b00});
    rst = 1'b1;
    #1;
    chk("rst_mid_own", outs(), 9'b0);
    #2;
    rst = 1'b0;
    step();
    chk("rst_after_idle", outs(), 9'b0);
`ifdef ARB_TIMEOUT_EN
    for (int g = 0; g < 2; g++) begin
      start = 1'b1; burst_len = 4'd0; gnt = 1'b0;
      step();
      start = 1'b0;
      for (int c = 1; c < 15; c++) begin
        step();
        chk($sformatf("to%0d_wait%0d", g, c), outs(), {3'b110, 4'd0, 2'b00});
      end
      gnt = (g == 1);
      step();
      chk($sformatf("to%0d_end", g), outs(), g ? {3'b111, 4'd0, 2'b00} : {3'b010, 4'd0, 2'b01});
      step();
      chk($sformatf("to%0d_after", g), outs(), g ? {3'b010, 4'd0, 2'b10} : 9'b0);
      gnt = 1'b0;
      step(); step();
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
